uart_rx_ctrl: RTL and testbench

Memory-mapped receive controller for the UART receiver. It captures each received byte (8-bit byte plus 1-cycle valid pulse) into a synchronous FIFO. The CPU data-memory bus reads bytes and status through three word registers, and the block raises a level interrupt. It sits between the UART receiver and the CPU bus decoder, in the CPU clock domain.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 76 +++++++
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller.
//   - Register word offsets (bus address bits [3:2])
//   - STATUS and CTRL register bit positions
package uart_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int unsigned ST_NEMPTY  = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVR     = 2;
    localparam int unsigned ST_TMO     = 3;
    localparam int unsigned ST_CNT_LSB = 8;

    localparam int unsigned CT_IRQEN  = 0;
    localparam int unsigned CT_FLUSH  = 1;
    localparam int unsigned CT_CLROVR = 2;
    localparam int unsigned CT_CLRTMO = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART receive controller.
// push/pop must already be qualified by the caller (no push when full
// without a pop, no pop when empty). flush has priority over both.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write strobe and byte
//   pop             advance read pointer
//   flush           empty the FIFO on the next edge
//   rdata           head byte, 0 while empty
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
        count = count_q;
        rdata = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped receive controller: buffers bytes from the UART receiver
// in a FIFO and exposes DATA / STATUS / CTRL words to the CPU bus.
// Optional idle-timeout flag: define UART_RX_TIMEOUT_EN.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   rx_byte, rx_dv   received byte and its one-cycle strobe
//   bus_addr         word select (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   bus_rd, bus_wr   one-cycle access strobes
//   bus_wdata        write data
//   bus_rdata        combinational read data
//   irq              registered level interrupt
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CNT_W        = $clog2(DEPTH) + 1,
    parameter int unsigned TIMEOUT_CLKS = 291680
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_dv,
    input  logic [1:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);

    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;

    logic data_rd, ctrl_wr, flush, pop_ok, push_ok, ovr_set, not_empty_d;
    logic overrun_q, overrun_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
    logic timeout_flag, timeout_nxt;
    logic unused_wdata;

    assign unused_wdata = ^bus_wdata[31:4];

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .flush (flush),
        .wdata (rx_byte),
        .rdata (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        data_rd = bus_rd && (bus_addr == REG_DATA);
        ctrl_wr = bus_wr && (bus_addr == REG_CTRL);
        flush   = ctrl_wr && bus_wdata[CT_FLUSH];
        pop_ok  = data_rd && !fifo_empty && !flush;
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push_ok = rx_dv && !flush && (!fifo_full || pop_ok);
        ovr_set = rx_dv && !flush && fifo_full && !pop_ok;

        overrun_d = ovr_set || (overrun_q && !(ctrl_wr && bus_wdata[CT_CLROVR]));
        irq_en_d  = ctrl_wr ? bus_wdata[CT_IRQEN] : irq_en_q;

        // Next-state occupancy > 0, without widening the counter.
        not_empty_d = !flush && (push_ok || (fifo_count > CNT_W'(pop_ok)));
        irq_d       = irq_en_d && (not_empty_d || overrun_d || timeout_nxt);
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d, tmo_set;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (push_ok || pop_ok || flush || fifo_empty) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        // Set only on the edge that reaches the limit, so a clear can win
        // while the counter sits saturated.
        tmo_set   = (tmo_cnt_d == TMO_MAX) && (tmo_cnt_q != TMO_MAX);
        timeout_d = tmo_set || (timeout_q && !(ctrl_wr && bus_wdata[CT_CLRTMO]));
        timeout_flag = timeout_q;
        timeout_nxt  = timeout_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    always_comb begin
        timeout_flag = 1'b0;
        timeout_nxt  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            REG_DATA: bus_rdata[7:0] = fifo_dout;
            REG_STATUS: begin
                bus_rdata[ST_NEMPTY]            = !fifo_empty;
                bus_rdata[ST_FULL]              = fifo_full;
                bus_rdata[ST_OVR]               = overrun_q;
                bus_rdata[ST_TMO]               = timeout_flag;
                bus_rdata[ST_CNT_LSB +: CNT_W]  = fifo_count;
            end
            REG_CTRL: bus_rdata[CT_IRQEN] = irq_en_q;
            default: bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_dv;
    logic [1:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    logic [31:0] v;

    uart_rx_ctrl #(
        .DEPTH        (16),
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_dv     (rx_dv),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start at a falling edge and end at the next falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0; rx_byte = '0;
    endtask

    task automatic rd_data(output logic [31:0] d);
        bus_addr = 2'd0; bus_rd = 1'b1;
        #1 d = bus_rdata;
        @(negedge clk);
        bus_rd = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        bus_addr = 2'd2; bus_wr = 1'b1; bus_wdata = d;
        @(negedge clk);
        bus_wr = 1'b0; bus_wdata = '0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        #1 d = bus_rdata;
    endtask

    initial begin
        rst_n = 1'b0; rx_byte = '0; rx_dv = 1'b0;
        bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        peek(2'd1, v); check("rst_status", v, 32'h0);
        peek(2'd0, v); check("rst_data", v, 32'h0);
        peek(2'd2, v); check("rst_ctrl", v, 32'h0);
        peek(2'd3, v); check("rst_rsvd", v, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Two bytes in, two out
        push(8'h41); push(8'h42);
        peek(2'd1, v); check("t1_status", v, 32'h0000_0201);
        rd_data(v); check("t1_rd0", v, 32'h41);
        rd_data(v); check("t1_rd1", v, 32'h42);
        peek(2'd1, v); check("t1_status_empty", v, 32'h0);

        // Overflow by one byte
        for (int i = 0; i < 17; i++) push(8'(i));
        peek(2'd1, v); check("t2_status_full", v, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            rd_data(v); check($sformatf("t2_rd%0d", i), v, 32'(i));
        end
        peek(2'd1, v); check("t2_status_drained", v, 32'h0000_0004);
        wr_ctrl(32'h4);
        peek(2'd1, v); check("t2_ovr_clr", v, 32'h0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        peek(2'd1, v); check("t3_status_full", v, 32'h0000_1003);
        rx_dv = 1'b1; rx_byte = 8'h99; bus_addr = 2'd0; bus_rd = 1'b1;
        #1 check("t3_rd_head", bus_rdata, 32'hA0);
        @(negedge clk);
        rx_dv = 1'b0; bus_rd = 1'b0;
        peek(2'd1, v); check("t3_status_after", v, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            rd_data(v);
            check($sformatf("t3_rd%0d", i), v, (i < 15) ? 32'hA1 + 32'(i) : 32'h99);
        end
        peek(2'd1, v); check("t3_status_empty", v, 32'h0);

        // Push and pop together while empty
        rx_dv = 1'b1; rx_byte = 8'h77; bus_addr = 2'd0; bus_rd = 1'b1;
        #1 check("e_rd_empty", bus_rdata, 32'h0);
        @(negedge clk);
        rx_dv = 1'b0; bus_rd = 1'b0;
        peek(2'd1, v); check("e_status", v, 32'h0000_0101);
        rd_data(v); check("e_rd", v, 32'h77);

        // Overflow and overrun-clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
        rx_dv = 1'b1; rx_byte = 8'hEE; bus_addr = 2'd2; bus_wr = 1'b1; bus_wdata = 32'h4;
        @(negedge clk);
        rx_dv = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
        peek(2'd1, v); check("o_set_wins", v, 32'h0000_1007);
        wr_ctrl(32'h2);
        peek(2'd1, v); check("o_flush_keeps_ovr", v, 32'h0000_0004);
        wr_ctrl(32'h4);
        peek(2'd1, v); check("o_clr", v, 32'h0);

        // Interrupt
        wr_ctrl(32'h1);
        peek(2'd2, v); check("t4_ctrl", v, 32'h1);
        check("t4_irq_idle", {31'b0, irq}, 32'h0);
        push(8'h55);
        check("t4_irq_rise", {31'b0, irq}, 32'h1);
        rd_data(v); check("t4_rd", v, 32'h55);
        check("t4_irq_fall", {31'b0, irq}, 32'h0);

        // Flush with a push in the same cycle
        push(8'hC1); push(8'hC2); push(8'hC3);
        peek(2'd1, v); check("t5_status3", v, 32'h0000_0301);
        rx_dv = 1'b1; rx_byte = 8'hEE; bus_addr = 2'd2; bus_wr = 1'b1; bus_wdata = 32'h2;
        @(negedge clk);
        rx_dv = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
        peek(2'd1, v); check("t5_status_flush", v, 32'h0);
        rd_data(v); check("t5_rd_empty", v, 32'h0);

        // Asynchronous reset mid-operation
        wr_ctrl(32'h1);
        push(8'h66);
        check("ar_irq_before", {31'b0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        peek(2'd1, v); check("ar_status", v, 32'h0);
        check("ar_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        rd_data(v); check("ar_rd", v, 32'h0);

`ifdef UART_RX_TIMEOUT_EN
        // Timeout after exactly 100 idle clocks
        push(8'hD1);
        idle(99);
        peek(2'd1, v); check("t6_tmo_99", v, 32'h0000_0101);
        idle(1);
        peek(2'd1, v); check("t6_tmo_100", v, 32'h0000_0109);
        rd_data(v); check("t6_rd", v, 32'hD1);
        peek(2'd1, v); check("t6_tmo_sticky", v, 32'h0000_0008);
        wr_ctrl(32'h8);
        peek(2'd1, v); check("t6_tmo_clr", v, 32'h0);
        push(8'hE1); push(8'hE2);
        idle(50);
        rd_data(v); check("t6_rd2", v, 32'hE1);
        idle(99);
        peek(2'd1, v); check("t6_pop_restart_99", v, 32'h0000_0101);
        idle(1);
        peek(2'd1, v); check("t6_pop_restart_100", v, 32'h0000_0109);
        wr_ctrl(32'hA);
        peek(2'd1, v); check("t6_flush_clr", v, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
